// File: rtl/mem_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and mem_responder (slave).
interface mem_responder_if;
  logic [31:0] byte_a;
  logic [7:0]  byte_din;
  logic        byte_wr;
  logic [7:0]  byte_dout;
  logic        io_buffer_full;

  modport master (output byte_a, byte_din, byte_wr, input byte_dout, io_buffer_full);
  modport slave  (input byte_a, byte_din, byte_wr, output byte_dout, io_buffer_full);
endinterface

// File: rtl/mem_responder.sv
// Byte RAM plus a memory-mapped UART port (TX FIFO, single-byte RX holding register).
// Address bits [17:16]==2'b11 select IO; offset 0x0 is data and offset 0x4 is status.
module mem_responder #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int TX_DEPTH       = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  mem_responder_if.slave        bus,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_valid,
  input  logic                  uart_tx_ready,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  sim_done,
  output logic                  tx_overflow,
  output logic                  rx_overrun
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] IO_DATA   = 16'h0000;
  localparam logic [15:0] IO_STATUS = 16'h0004;

  logic [7:0] ram_mem [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_mem  [TX_DEPTH];

  logic [7:0]    byte_dout_q, byte_dout_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic          rx_full_q, rx_full_d;
  logic          sim_done_q, sim_done_d;
  logic          tx_overflow_q, tx_overflow_d;
  logic          rx_overrun_q, rx_overrun_d;

  logic                      is_io;
  logic [15:0]               io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      ram_we, tx_push_req, tx_push, tx_pop, rx_read, rx_strobe;
  logic                      tx_full, tx_empty;
  logic                      unused_addr_bits;

  assign is_io            = bus.byte_a[17:16] == 2'b11;
  assign io_off           = bus.byte_a[15:0];
  assign ram_idx          = bus.byte_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.byte_a;

  assign tx_full     = count_q == CW'(TX_DEPTH);
  assign tx_empty    = count_q == '0;
  assign ram_we      = rdy_in & bus.byte_wr & ~is_io;
  assign tx_push_req = rdy_in & bus.byte_wr & is_io & (io_off == IO_DATA);
  assign tx_pop      = rdy_in & ~tx_empty & uart_tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_read     = rdy_in & ~bus.byte_wr & is_io & (io_off == IO_DATA);
  assign rx_strobe   = rdy_in & uart_rx_valid;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    byte_dout_d   = byte_dout_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rx_hold_d     = rx_hold_q;
    rx_full_d     = rx_full_q;
    sim_done_d    = sim_done_q;
    tx_overflow_d = tx_overflow_q;
    rx_overrun_d  = rx_overrun_q;

    if (rdy_in) begin
      if (bus.byte_wr) begin
        byte_dout_d = 8'h00;
      end else if (is_io) begin
        case (io_off)
          IO_DATA:   byte_dout_d = rx_full_q ? rx_hold_q : 8'h00;
          IO_STATUS: byte_dout_d = {5'b0, rx_full_q, tx_empty, tx_full};
          default:   byte_dout_d = 8'h00;
        endcase
      end else begin
        byte_dout_d = ram_mem[ram_idx];
      end
    end

    if (tx_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (tx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (tx_push && !tx_pop)      count_d = count_q + 1'b1;
    else if (!tx_push && tx_pop) count_d = count_q - 1'b1;
    if (tx_push_req && !tx_push) tx_overflow_d = 1'b1;

    if (rdy_in && bus.byte_wr && is_io && io_off == IO_STATUS) sim_done_d = 1'b1;

    // A read of the data register frees the holder, so a same-cycle strobe is not an overrun.
    if (rx_strobe) begin
      if (!rx_full_q || rx_read) begin
        rx_hold_d = uart_rx_data;
        rx_full_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_read) begin
      rx_full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      byte_dout_q   <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_hold_q     <= 8'h00;
      rx_full_q     <= 1'b0;
      sim_done_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      byte_dout_q   <= byte_dout_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rx_hold_q     <= rx_hold_d;
      rx_full_q     <= rx_full_d;
      sim_done_q    <= sim_done_d;
      tx_overflow_q <= tx_overflow_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  // NOTE: storage arrays carry no reset; their contents survive rst_n_in and map onto RAM.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram_mem[ram_idx] <= bus.byte_din;
    if (tx_push) tx_mem[wr_ptr_q] <= bus.byte_din;
  end

  assign bus.byte_dout      = byte_dout_q;
  assign bus.io_buffer_full = tx_full;
  assign uart_tx_valid      = ~tx_empty;
  assign uart_tx_data       = tx_empty ? 8'h00 : tx_mem[rd_ptr_q];
  assign sim_done           = sim_done_q;
  assign tx_overflow        = tx_overflow_q;
  assign rx_overrun         = rx_overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a RAM/IO vector table followed by FIFO, RX, enable and reset sequences.
module tb_mem_responder;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       rdy_in;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       sim_done, tx_overflow, rx_overrun;

  mem_responder_if bus_if();

  mem_responder dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .bus           (bus_if),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .sim_done      (sim_done),
    .tx_overflow   (tx_overflow),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  din;
    logic        wr;
    logic [7:0]  exp_dout;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] din, input logic wr);
    bus_if.byte_a   = a;
    bus_if.byte_din = din;
    bus_if.byte_wr  = wr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},     {24'h0, bus_if.byte_dout}, 32'h0);
    check({tag, "_full"},     {31'h0, bus_if.io_buffer_full}, 32'h0);
    check({tag, "_txvalid"},  {31'h0, uart_tx_valid}, 32'h0);
    check({tag, "_txdata"},   {24'h0, uart_tx_data}, 32'h0);
    check({tag, "_simdone"},  {31'h0, sim_done}, 32'h0);
    check({tag, "_overflow"}, {31'h0, tx_overflow}, 32'h0);
    check({tag, "_overrun"},  {31'h0, rx_overrun}, 32'h0);
  endtask

  vec_t vecs [15];
  logic [7:0] exp_b [8];

  initial begin
    vecs[0]  = '{32'h0000_0010, 8'hA5, 1'b1, 8'h00};
    vecs[1]  = '{32'h0000_0010, 8'h00, 1'b0, 8'hA5};
    vecs[2]  = '{32'h0000_0011, 8'h3C, 1'b1, 8'h00};
    vecs[3]  = '{32'h0000_0011, 8'h00, 1'b0, 8'h3C};
    vecs[4]  = '{32'h0000_0010, 8'h00, 1'b0, 8'hA5};
    vecs[5]  = '{32'h0000_FFFF, 8'h7E, 1'b1, 8'h00};
    vecs[6]  = '{32'h0000_FFFF, 8'h00, 1'b0, 8'h7E};
    vecs[7]  = '{32'h1000_0010, 8'h00, 1'b0, 8'hA5};
    vecs[8]  = '{32'h0002_0011, 8'h00, 1'b0, 8'h3C};
    vecs[9]  = '{32'h0003_0004, 8'h00, 1'b0, 8'h02};
    vecs[10] = '{32'h0003_0008, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{32'h0001_0010, 8'h00, 1'b0, 8'hA5};
    vecs[12] = '{32'h0003_0008, 8'h99, 1'b1, 8'h00};
    vecs[13] = '{32'h0003_0004, 8'h00, 1'b0, 8'h02};
    vecs[14] = '{32'h0003_0000, 8'h00, 1'b0, 8'h00};

    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    uart_tx_ready = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_valid = 1'b0;
    drive(32'h0, 8'h00, 1'b0);
    #1;
    check_all_zero("reset");
    cyc();
    cyc();
    rst_n_in = 1'b1;

    // RAM and IO decode vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].din, vecs[i].wr);
      cyc();
      check($sformatf("vec%0d", i), {24'h0, bus_if.byte_dout}, {24'h0, vecs[i].exp_dout});
    end
    check("vec_no_push", {31'h0, uart_tx_valid}, 32'h0);

    // Fill FIFO with consumer stalled, overflow, then drain in order
    for (int i = 0; i < 8; i++) begin
      drive(32'h0003_0000, 8'h41 + 8'(i), 1'b1);
      cyc();
      check($sformatf("fill_full%0d", i), {31'h0, bus_if.io_buffer_full}, {31'h0, i == 7});
    end
    drive(32'h0003_0000, 8'h49, 1'b1);
    cyc();
    check("overflow_set", {31'h0, tx_overflow}, 32'h1);
    drive(32'h0000_0010, 8'h00, 1'b0);
    uart_tx_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("drain_valid%0d", j), {31'h0, uart_tx_valid}, 32'h1);
      check($sformatf("drain_data%0d", j), {24'h0, uart_tx_data}, {24'h0, 8'h41 + 8'(j)});
      cyc();
    end
    check("drain_empty", {31'h0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    rst_n_in = 1'b0;
    #2;
    rst_n_in = 1'b1;
    check("rst_clears_overflow", {31'h0, tx_overflow}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(32'h0003_0000, 8'h10 + 8'(i), 1'b1);
      cyc();
    end
    check("pp_full_before", {31'h0, bus_if.io_buffer_full}, 32'h1);
    drive(32'h0003_0000, 8'h55, 1'b1);
    uart_tx_ready = 1'b1;
    check("pp_head", {24'h0, uart_tx_data}, 32'h10);
    cyc();
    check("pp_full_after", {31'h0, bus_if.io_buffer_full}, 32'h1);
    check("pp_no_overflow", {31'h0, tx_overflow}, 32'h0);
    drive(32'h0000_0010, 8'h00, 1'b0);
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int j = 0; j < 8; j++) begin
      check($sformatf("pp_data%0d", j), {24'h0, uart_tx_data}, {24'h0, exp_b[j]});
      cyc();
    end
    check("pp_empty", {31'h0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // RX holding register, overrun and same-cycle read+strobe
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h33;
    cyc();
    uart_rx_data  = 8'h44;
    cyc();
    uart_rx_valid = 1'b0;
    check("rx_overrun", {31'h0, rx_overrun}, 32'h1);
    drive(32'h0003_0004, 8'h00, 1'b0);
    cyc();
    check("rx_status_full", {24'h0, bus_if.byte_dout}, 32'h06);
    drive(32'h0003_0000, 8'h00, 1'b0);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h77;
    cyc();
    uart_rx_valid = 1'b0;
    check("rx_read_old", {24'h0, bus_if.byte_dout}, 32'h33);
    drive(32'h0003_0004, 8'h00, 1'b0);
    cyc();
    check("rx_still_full", {24'h0, bus_if.byte_dout}, 32'h06);
    drive(32'h0003_0000, 8'h00, 1'b0);
    cyc();
    check("rx_read_new", {24'h0, bus_if.byte_dout}, 32'h77);
    drive(32'h0003_0004, 8'h00, 1'b0);
    cyc();
    check("rx_status_empty", {24'h0, bus_if.byte_dout}, 32'h02);
    drive(32'h0003_0000, 8'h00, 1'b0);
    cyc();
    check("rx_read_empty", {24'h0, bus_if.byte_dout}, 32'h00);

    // Enable low freezes RAM, FIFO, RX and byte_dout
    drive(32'h0000_0100, 8'h11, 1'b1);
    cyc();
    drive(32'h0003_0000, 8'h5A, 1'b1);
    cyc();
    drive(32'h0000_0100, 8'h00, 1'b0);
    cyc();
    check("rdy_pre_dout", {24'h0, bus_if.byte_dout}, 32'h11);
    rdy_in        = 1'b0;
    uart_tx_ready = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h99;
    for (int k = 0; k < 3; k++) begin
      drive((k == 1) ? 32'h0003_0000 : 32'h0000_0100, 8'hEE, 1'b1);
      cyc();
      check($sformatf("rdy_hold_dout%0d", k), {24'h0, bus_if.byte_dout}, 32'h11);
      check($sformatf("rdy_hold_valid%0d", k), {31'h0, uart_tx_valid}, 32'h1);
      check($sformatf("rdy_hold_data%0d", k), {24'h0, uart_tx_data}, 32'h5A);
    end
    rdy_in        = 1'b1;
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0;
    drive(32'h0000_0100, 8'h00, 1'b0);
    cyc();
    check("rdy_ram_kept", {24'h0, bus_if.byte_dout}, 32'h11);
    drive(32'h0003_0004, 8'h00, 1'b0);
    cyc();
    check("rdy_status", {24'h0, bus_if.byte_dout}, 32'h00);
    drive(32'h0000_0100, 8'h00, 1'b0);
    uart_tx_ready = 1'b1;
    cyc();
    check("rdy_one_pop", {31'h0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // sim_done sticky, then asynchronous reset mid-stream
    drive(32'h0003_0004, 8'h01, 1'b1);
    cyc();
    check("simdone_set", {31'h0, sim_done}, 32'h1);
    drive(32'h0003_0000, 8'h66, 1'b1);
    cyc();
    drive(32'h0000_0100, 8'h00, 1'b0);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'hAB;
    cyc();
    uart_rx_valid = 1'b0;
    cyc();
    cyc();
    check("simdone_sticky", {31'h0, sim_done}, 32'h1);
    check("pre_reset_valid", {31'h0, uart_tx_valid}, 32'h1);
    check("pre_reset_dout", {24'h0, bus_if.byte_dout}, 32'h11);
    #3;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("async_rst");
    cyc();
    check("rst_read_aborted", {24'h0, bus_if.byte_dout}, 32'h00);
    rst_n_in = 1'b1;
    cyc();
    check("ram_survives_reset", {24'h0, bus_if.byte_dout}, 32'h11);
    check("post_rst_simdone", {31'h0, sim_done}, 32'h0);
    check("post_rst_empty", {31'h0, uart_tx_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 16: RAM size 2^RAM_ADDR_WIDTH bytes.
REQ-002 SHALL have parameter TX_DEPTH, default 8, power of two: UART TX FIFO entries.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port byte_a  input  32  byte address from the memory controller.
REQ-007 SHALL have port byte_din  input  8  write data.
REQ-008 SHALL have port byte_wr  input  1  1 = write, 0 = read.
REQ-009 SHALL have port byte_dout  output  8  registered read data.
REQ-010 SHALL have port io_buffer_full  output  1  TX FIFO full, combinational from the FIFO count.
REQ-011 SHALL have ports uart_tx_data (output, 8) and uart_tx_valid (output, 1): head of the TX FIFO.
REQ-012 SHALL have port uart_tx_ready  input  1  consumer accepts head.
REQ-013 SHALL have ports uart_rx_data (input, 8) and uart_rx_valid (input, 1): one-cycle receive strobe.
REQ-014 SHALL have ports sim_done (output, 1), tx_overflow (output, 1) and rx_overrun (output, 1): sticky flags.

Function
REQ-015 SHALL decode IO when byte_a[17:16]==2'b11; otherwise RAM index byte_a[RAM_ADDR_WIDTH-1:0], upper bits ignored.
REQ-016 SHALL sample byte_a/byte_din/byte_wr every enabled edge; RAM write takes effect at that edge.
REQ-017 SHALL present read data on byte_dout at the edge after the address is sampled (latency 1); every RAM address SHALL be readable on back-to-back cycles.
REQ-018 SHALL drive byte_dout with 8'h00 after any write cycle.
REQ-019 SHALL give read-after-write to the same address on the next cycle the newly written byte.
REQ-020 IO write 0x30000 SHALL push byte_din into the TX FIFO; when full, the write is dropped and tx_overflow is set.
REQ-021 IO write 0x30004 SHALL set sim_done; the flag stays set until reset.
REQ-022 IO read 0x30000 SHALL return rx_hold and clear rx_full; when rx_full=0 it returns 8'h00.
REQ-023 IO read 0x30004 SHALL return {5'b0, rx_full, tx_empty, io_buffer_full}; other IO offsets read 8'h00 and ignore writes.
REQ-024 TX FIFO SHALL pop the head on uart_tx_valid && uart_tx_ready; uart_tx_valid = count!=0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push to a full FIFO with a same-cycle pop SHALL be accepted.
REQ-026 Pointers SHALL wrap modulo TX_DEPTH; count width SHALL be log2(TX_DEPTH)+1.
REQ-027 uart_rx_valid with rx_full=0 SHALL load rx_hold and set rx_full.
REQ-028 uart_rx_valid with rx_full=1 SHALL drop the byte, keep rx_hold and set rx_overrun; exception: a same-cycle IO read of 0x30000 loads the new byte and rx_full stays 1.
REQ-029 rdy_in=0 SHALL ignore bus and RX inputs, hold byte_dout, and block FIFO push/pop; uart_tx_valid still reflects count.

Reset
REQ-030 rst_n_in low SHALL immediately force: byte_dout=0, FIFO pointers/count=0, rx_hold=0, rx_full=0, sim_done=0, tx_overflow=0, rx_overrun=0.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 Reset asserted mid-transaction SHALL abort it: a pending read returns 0 and an in-flight IO push is lost.

Verification
REQ-033 Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> byte_dout=0xA5 one cycle after the read address.
REQ-034 Write 0x41..0x48 to 0x30000 with uart_tx_ready=0 -> io_buffer_full=1 after the 8th write; a 9th write -> tx_overflow=1; raising ready -> bytes 0x41..0x48 emerge in order.
REQ-035 Full FIFO with simultaneous push 0x55 and pop -> count stays 8, 0x55 is last out, tx_overflow stays 0.
REQ-036 rx strobe 0x33, then rx strobe 0x44 -> rx_overrun=1 and a read of 0x30000 returns 0x33; a read with same-cycle strobe 0x77 -> returns 0x33, rx_full=1, next read returns 0x77.
REQ-037 Write to 0x30004 -> sim_done=1 and stays set; assert rst_n_in low asynchronously mid-stream -> all outputs 0 without a clock edge.
REQ-038 rdy_in=0 for 3 cycles during a write burst -> RAM, FIFO and byte_dout unchanged during those cycles.
